inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch initiator for the 32-bit in-order pipeline.
- Generates the PC and chip-enable that drive the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register.
- Handles stall, branch redirect (including a branch that arrives during a stall), pipeline flush, and an optional branch-delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DELAY_SLOT, 1, 1 = the instruction after a branch executes; 0 = it is squashed.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_if  in  1  hold PC, no new fetch this cycle
- stall_id  in  1  hold the IF/ID register
- flush  in  1  exception/eret flush
- flush_pc  in  32  redirect target on flush
- branch_flag  in  1  taken branch from ID, one-cycle pulse
- branch_target  in  32  branch destination
- rom_ce  out  1  ROM chip enable
- rom_addr  out  32  ROM byte address, equals pc
- rom_inst  in  32  ROM data, valid in the same cycle as rom_addr
- id_pc  out  32  PC of the instruction in IF/ID
- id_inst  out  32  instruction in IF/ID
- id_valid  out  1  IF/ID holds a real instruction

Behaviour:

Reset (async, rst_n=0):
- pc=RESET_PC, rom_ce=0, br_pend=0, br_pend_tgt=0.
- id_pc=0, id_inst=0, id_valid=0.
- All registers clear immediately, mid-operation included.

Enable sequence (states):
- IDLE: rom_ce=0 → RUN at the first rising edge with rst_n=1.
- RUN: rom_ce=1 and stays 1 until reset.
- pc does not change in IDLE.
- First fetch of RESET_PC occurs in the first RUN cycle.

Next-pc priority, evaluated in RUN, highest first:
1. flush: pc←flush_pc; br_pend←0.
2. stall_if and branch_flag: pc held; br_pend←1, br_pend_tgt←branch_target.
3. stall_if: pc held; br_pend held.
4. br_pend: pc←br_pend_tgt; br_pend←0.
5. branch_flag: pc←branch_target.
6. Otherwise: pc←pc+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.

Address rules:
- Targets have bits [1:0] forced to 0 before being loaded into pc.
- rom_addr = pc combinationally, for both pc and pending-branch loads.

IF/ID register update, highest first:
1. flush: id_valid←0, id_inst←0, id_pc←0.
2. stall_id: hold all fields.
3. stall_if: bubble (id_valid←0, id_inst←0, id_pc←0).
4. branch_flag=1, or br_pend applied, with DELAY_SLOT=0: bubble.
5. Otherwise: id_pc←pc, id_inst←rom_inst, id_valid←rom_ce.

Latency:
- Instruction at pc appears on id_* one edge after the cycle it is addressed.
- Branch redirect: target is addressed in the cycle after branch_flag.
- Flush redirect: flush_pc is addressed in the cycle after flush.

Simultaneous events:
- flush together with anything: flush wins.
- branch_flag together with a live br_pend and no stall: the new branch_flag is ignored. The ID stage guarantees this combination never occurs; the bench flags it as an assertion.
- rom_ce=0 never produces id_valid=1.

Test Plan:
- Reset release, no stalls → rom_ce rises at edge 1; rom_addr sequence 0,4,8,C; id_inst tracks ROM words one cycle later; id_valid=1 from edge 2.
- branch_flag=1 with branch_target=32'h40 while pc=8, DELAY_SLOT=1 → id_inst = word at 8, then rom_addr=40; DELAY_SLOT=0 → id_valid=0 for that slot.
- stall_if=1 for 3 cycles with branch_flag pulsed in stall cycle 1 (target 32'h100) → pc held, id_valid=0 during stall; first cycle after the stall releases addresses 32'h100.
- flush=1, flush_pc=32'h20, asserted concurrently with stall_if and branch_flag → next rom_addr=20, id_valid=0, br_pend cleared.
- Force pc=32'hFFFF_FFFC with no stall → next rom_addr=0; branch_target=32'h13 → rom_addr=32'h10.
- Assert rst_n=0 asynchronously mid-stream with a pending branch → all outputs zero immediately; after release the sequence restarts at RESET_PC and no stale branch is taken.

Source files
------------

// File: rtl/inst_fetch_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_if
//   Bundles the instruction-fetch control inputs, the instruction ROM bus and
//   the IF/ID pipeline register outputs into one interface.
//
//   master : the fetch unit (drives rom_ce/rom_addr and the id_* fields)
//   slave  : the surrounding pipeline and ROM (drives stalls, flush, branch
//            and rom_inst)
//
//   Signals
//     stall_if       hold PC, no new fetch this cycle
//     stall_id       hold the IF/ID register
//     flush          exception/eret flush
//     flush_pc[31:0] redirect target on flush
//     branch_flag    taken branch from ID, one-cycle pulse
//     branch_target  branch destination
//     rom_ce         ROM chip enable
//     rom_addr       ROM byte address (equals pc)
//     rom_inst       ROM data, valid in the same cycle as rom_addr
//     id_pc          PC of the instruction in IF/ID
//     id_inst        instruction in IF/ID
//     id_valid       IF/ID holds a real instruction
// ----------------------------------------------------------------------------
interface inst_fetch_if;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    modport master (
        input  stall_if,
        input  stall_id,
        input  flush,
        input  flush_pc,
        input  branch_flag,
        input  branch_target,
        input  rom_inst,
        output rom_ce,
        output rom_addr,
        output id_pc,
        output id_inst,
        output id_valid
    );

    modport slave (
        output stall_if,
        output stall_id,
        output flush,
        output flush_pc,
        output branch_flag,
        output branch_target,
        output rom_inst,
        input  rom_ce,
        input  rom_addr,
        input  id_pc,
        input  id_inst,
        input  id_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch initiator for the 32-bit in-order pipeline. Generates
//   the PC / chip enable for a combinational instruction ROM and captures the
//   returned word into the IF/ID pipeline register. Handles stall, branch
//   redirect (remembering a branch that arrives while IF is stalled),
//   pipeline flush and an optional branch-delay slot.
//
//   Parameters
//     RESET_PC    first fetch address after reset
//     DELAY_SLOT  1: the instruction after a branch executes, 0: squashed
//
//   Ports
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      inst_fetch_if.master (control inputs, ROM bus, IF/ID outputs)
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    inst_fetch_if.master  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_rom_ce;
    logic [31:0] r_pc;
    logic        r_br_pend;
    logic [31:0] r_br_pend_tgt;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;

    logic        w_run;
    logic        w_pend_apply;
    logic        w_squash;
    logic [31:0] w_flush_tgt;
    logic [31:0] w_branch_tgt;

    // Redirect targets are always word aligned.
    assign w_flush_tgt  = {bus.flush_pc[31:2], 2'b00};
    assign w_branch_tgt = {bus.branch_target[31:2], 2'b00};

    assign w_run = (r_state == S_RUN);

    // A remembered branch is taken in the first un-stalled, un-flushed RUN
    // cycle; that cycle's fetch is the delay slot of the remembered branch.
    assign w_pend_apply = w_run & ~bus.flush & ~bus.stall_if & r_br_pend;

    // Without a delay slot, the word fetched alongside a redirect is dropped.
    assign w_squash = (DELAY_SLOT == 1'b0) & (bus.branch_flag | w_pend_apply);

    // ------------------------------------------------------------------------
    // Enable FSM and next-pc selection.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rom_ce      <= 1'b0;
            r_pc          <= RESET_PC;
            r_br_pend     <= 1'b0;
            r_br_pend_tgt <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // pc stays at RESET_PC; it is fetched in the first RUN cycle.
                    r_state  <= S_RUN;
                    r_rom_ce <= 1'b1;
                end
                S_RUN: begin
                    r_rom_ce <= 1'b1;
                    if (bus.flush) begin
                        r_pc      <= w_flush_tgt;
                        r_br_pend <= 1'b0;
                    end else if (bus.stall_if) begin
                        // pc held; a branch seen now is replayed after the stall.
                        if (bus.branch_flag) begin
                            r_br_pend     <= 1'b1;
                            r_br_pend_tgt <= w_branch_tgt;
                        end
                    end else if (r_br_pend) begin
                        // Any simultaneous branch_flag is ignored here.
                        r_pc      <= r_br_pend_tgt;
                        r_br_pend <= 1'b0;
                    end else if (bus.branch_flag) begin
                        r_pc <= w_branch_tgt;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rom_ce <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (bus.flush) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (bus.stall_id) begin
            r_id_pc    <= r_id_pc;
            r_id_inst  <= r_id_inst;
            r_id_valid <= r_id_valid;
        end else if (bus.stall_if || w_squash) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else begin
            // rom_ce low (IDLE) yields an invalid entry.
            r_id_pc    <= r_pc;
            r_id_inst  <= bus.rom_inst;
            r_id_valid <= r_rom_ce;
        end
    end

    assign bus.rom_ce   = r_rom_ce;
    assign bus.rom_addr = r_pc;
    assign bus.id_pc    = r_id_pc;
    assign bus.id_inst  = r_id_inst;
    assign bus.id_valid = r_id_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//   Two instances share all stimulus: dut1 with DELAY_SLOT=1, dut0 with
//   DELAY_SLOT=0. Directed scenarios check hand-derived constants; a random
//   scenario checks every output of both instances against a reference model.
// ----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_sif, t_sid, t_fl, t_bf;
    logic [31:0] t_fpc, t_bt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch_if bus0();
    inst_fetch_if bus1();

    // Instruction ROM contents: a fixed scramble of the byte address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus0.stall_if      = t_sif;
    assign bus0.stall_id      = t_sid;
    assign bus0.flush         = t_fl;
    assign bus0.flush_pc      = t_fpc;
    assign bus0.branch_flag   = t_bf;
    assign bus0.branch_target = t_bt;
    assign bus0.rom_inst      = rom_word(bus0.rom_addr);

    assign bus1.stall_if      = t_sif;
    assign bus1.stall_id      = t_sid;
    assign bus1.flush         = t_fl;
    assign bus1.flush_pc      = t_fpc;
    assign bus1.branch_flag   = t_bf;
    assign bus1.branch_target = t_bt;
    assign bus1.rom_inst      = rom_word(bus1.rom_addr);

    inst_fetch #(.RESET_PC(RESET_PC), .DELAY_SLOT(1'b1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    inst_fetch #(.RESET_PC(RESET_PC), .DELAY_SLOT(1'b0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    function automatic logic        d_ce(input int d);    return d != 0 ? bus1.rom_ce   : bus0.rom_ce;   endfunction
    function automatic logic [31:0] d_addr(input int d);  return d != 0 ? bus1.rom_addr : bus0.rom_addr; endfunction
    function automatic logic        d_idv(input int d);   return d != 0 ? bus1.id_valid : bus0.id_valid; endfunction
    function automatic logic [31:0] d_idpc(input int d);  return d != 0 ? bus1.id_pc    : bus0.id_pc;    endfunction
    function automatic logic [31:0] d_idins(input int d); return d != 0 ? bus1.id_inst  : bus0.id_inst;  endfunction

    // ------------------------------------------------------------------------
    // Reference model: fetch address, a remembered redirect, and per-instance
    // IF/ID contents (index = DELAY_SLOT value).
    // ------------------------------------------------------------------------
    logic        m_started;
    logic [31:0] m_pc;
    logic        m_has_redirect;
    logic [31:0] m_redirect;
    logic        m_idv   [2];
    logic [31:0] m_idpc  [2];
    logic [31:0] m_idins [2];

    task automatic model_reset();
        m_started      = 1'b0;
        m_pc           = RESET_PC;
        m_has_redirect = 1'b0;
        m_redirect     = 32'h0;
        for (int d = 0; d < 2; d++) begin
            m_idv[d]   = 1'b0;
            m_idpc[d]  = 32'h0;
            m_idins[d] = 32'h0;
        end
    endtask

    // One rising edge with rst_n high, using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] fetched_pc;
        logic        fetching, redirecting, replay;
        fetched_pc  = m_pc;
        fetching    = m_started;
        replay      = m_started && !t_fl && !t_sif && m_has_redirect;
        redirecting = t_bf || replay;
        for (int d = 0; d < 2; d++) begin
            if (t_fl || (!t_sid && (t_sif || (d == 0 && redirecting)))) begin
                m_idv[d] = 1'b0; m_idpc[d] = 32'h0; m_idins[d] = 32'h0;
            end else if (!t_sid) begin
                m_idv[d] = fetching; m_idpc[d] = fetched_pc; m_idins[d] = rom_word(fetched_pc);
            end
        end
        if (m_started) begin
            if (t_fl) begin
                m_pc = {t_fpc[31:2], 2'b00};
                m_has_redirect = 1'b0;
            end else if (t_sif) begin
                if (t_bf) begin
                    m_has_redirect = 1'b1;
                    m_redirect = {t_bt[31:2], 2'b00};
                end
            end else if (replay) begin
                m_pc = m_redirect;
                m_has_redirect = 1'b0;
            end else if (t_bf) begin
                m_pc = {t_bt[31:2], 2'b00};
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
    endtask

    // Advance one clock: inputs were set at the preceding negedge, outputs
    // are read at the following negedge.
    task automatic tick();
        assert (!(rst_n && m_has_redirect && t_bf && !t_sif && !t_fl))
            else $error("branch_flag raised while a remembered redirect is live");
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        $display("cyc t=%0t addr=%h ce=%b | ds1 v=%b pc=%h inst=%h | ds0 v=%b pc=%h inst=%h",
                 $time, bus1.rom_addr, bus1.rom_ce, bus1.id_valid, bus1.id_pc, bus1.id_inst,
                 bus0.id_valid, bus0.id_pc, bus0.id_inst);
    endtask

    task automatic clear_inputs();
        t_sif = 1'b0; t_sid = 1'b0; t_fl = 1'b0; t_bf = 1'b0;
        t_fpc = 32'h0; t_bt = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_ce(d) !== 1'b0 || d_addr(d) !== RESET_PC || d_idv(d) !== 1'b0 ||
                d_idpc(d) !== 32'h0 || d_idins(d) !== 32'h0) begin
                bad++;
                $display("FAIL reset_state dut%0d got ce=%b addr=%h v=%b pc=%h inst=%h want 0,%h,0,0,0",
                         d, d_ce(d), d_addr(d), d_idv(d), d_idpc(d), d_idins(d), RESET_PC);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_ce(d) !== 1'b1 || d_addr(d) !== 32'(4 * k)) begin
                    bad++;
                    $display("FAIL startup_addr dut%0d k=%0d got ce=%b addr=%h want 1,%h",
                             d, k, d_ce(d), d_addr(d), 32'(4 * k));
                end
                total++;
                if (k == 0 && d_idv(d) !== 1'b0) begin
                    bad++;
                    $display("FAIL startup_idle_valid dut%0d got=%b want=0", d, d_idv(d));
                end else if (k > 0 && (d_idv(d) !== 1'b1 || d_idpc(d) !== 32'(4 * (k - 1)) ||
                                       d_idins(d) !== rom_word(32'(4 * (k - 1))))) begin
                    bad++;
                    $display("FAIL startup_ifid dut%0d k=%0d got v=%b pc=%h inst=%h want 1,%h,%h",
                             d, k, d_idv(d), d_idpc(d), d_idins(d), 32'(4 * (k - 1)),
                             rom_word(32'(4 * (k - 1))));
                end
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        tick(); tick(); tick();
        total++;
        if (bus1.rom_addr !== 32'h8) begin
            bad++;
            $display("FAIL branch_setup got=%h want=00000008", bus1.rom_addr);
        end
        t_bf = 1'b1; t_bt = 32'h40;
        tick();
        t_bf = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h40) begin
                bad++;
                $display("FAIL branch_redirect dut%0d got=%h want=00000040", d, d_addr(d));
            end
        end
        total++;
        if (bus1.id_valid !== 1'b1 || bus1.id_pc !== 32'h8 || bus1.id_inst !== rom_word(32'h8)) begin
            bad++;
            $display("FAIL branch_delay_slot got v=%b pc=%h inst=%h want 1,00000008,%h",
                     bus1.id_valid, bus1.id_pc, bus1.id_inst, rom_word(32'h8));
        end
        total++;
        if (bus0.id_valid !== 1'b0) begin
            bad++;
            $display("FAIL branch_squash got v=%b want=0", bus0.id_valid);
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h44 || d_idv(d) !== 1'b1 || d_idins(d) !== rom_word(32'h40)) begin
                bad++;
                $display("FAIL branch_target_fetch dut%0d got addr=%h v=%b inst=%h want 00000044,1,%h",
                         d, d_addr(d), d_idv(d), d_idins(d), rom_word(32'h40));
            end
        end
    endtask

    task automatic test_stall_branch();
        t_sif = 1'b1; t_bf = 1'b1; t_bt = 32'h100;
        for (int k = 0; k < 3; k++) begin
            tick();
            t_bf = 1'b0;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_addr(d) !== 32'h44 || d_idv(d) !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold dut%0d k=%0d got addr=%h v=%b want 00000044,0",
                             d, k, d_addr(d), d_idv(d));
                end
            end
        end
        t_sif = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h100) begin
                bad++;
                $display("FAIL stall_pending_branch dut%0d got=%h want=00000100", d, d_addr(d));
            end
        end
        total++;
        if (bus1.id_valid !== 1'b1 || bus1.id_pc !== 32'h44) begin
            bad++;
            $display("FAIL stall_delay_slot got v=%b pc=%h want 1,00000044", bus1.id_valid, bus1.id_pc);
        end
        total++;
        if (bus0.id_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_squash got v=%b want=0", bus0.id_valid);
        end
    endtask

    task automatic test_flush();
        t_sif = 1'b1; t_bf = 1'b1; t_bt = 32'h300;
        tick();
        t_fl = 1'b1; t_fpc = 32'h20;
        tick();
        clear_inputs();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h20 || d_idv(d) !== 1'b0) begin
                bad++;
                $display("FAIL flush_redirect dut%0d got addr=%h v=%b want 00000020,0", d, d_addr(d), d_idv(d));
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h24 || d_idv(d) !== 1'b1 || d_idpc(d) !== 32'h20) begin
                bad++;
                $display("FAIL flush_clears_pending dut%0d got addr=%h v=%b pc=%h want 00000024,1,00000020",
                         d, d_addr(d), d_idv(d), d_idpc(d));
            end
        end
    endtask

    task automatic test_wrap();
        t_bf = 1'b1; t_bt = 32'hFFFF_FFFC;
        tick();
        t_bf = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h0 || d_idpc(d) !== 32'hFFFF_FFFC) begin
                bad++;
                $display("FAIL pc_wrap dut%0d got addr=%h idpc=%h want 00000000,fffffffc", d, d_addr(d), d_idpc(d));
            end
        end
        t_bf = 1'b1; t_bt = 32'h13;
        tick();
        t_bf = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_addr(d) !== 32'h10) begin
                bad++;
                $display("FAIL target_align dut%0d got=%h want=00000010", d, d_addr(d));
            end
        end
    endtask

    task automatic test_async_reset();
        t_sif = 1'b1; t_bf = 1'b1; t_bt = 32'h500;
        tick();
        t_bf = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_ce(d) !== 1'b0 || d_addr(d) !== RESET_PC || d_idv(d) !== 1'b0 ||
                d_idpc(d) !== 32'h0 || d_idins(d) !== 32'h0) begin
                bad++;
                $display("FAIL async_reset dut%0d got ce=%b addr=%h v=%b pc=%h inst=%h want all zero",
                         d, d_ce(d), d_addr(d), d_idv(d), d_idpc(d), d_idins(d));
            end
        end
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_ce(d) !== 1'b1 || d_addr(d) !== 32'(4 * k)) begin
                    bad++;
                    $display("FAIL restart_no_stale dut%0d k=%0d got ce=%b addr=%h want 1,%h",
                             d, k, d_ce(d), d_addr(d), 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            t_fl  = ($urandom_range(0, 19) == 0);
            t_sif = ($urandom_range(0, 3) == 0);
            t_sid = ($urandom_range(0, 4) == 0);
            t_bf  = ($urandom_range(0, 4) == 0);
            t_bt  = $urandom;
            t_fpc = $urandom;
            // ID never raises a branch while a remembered redirect is about to be taken.
            if (m_has_redirect && !t_sif && !t_fl) t_bf = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_ce(d) !== m_started || d_addr(d) !== m_pc) begin
                    bad++;
                    $display("FAIL rand_fetch dut%0d n=%0d got ce=%b addr=%h want %b,%h",
                             d, n, d_ce(d), d_addr(d), m_started, m_pc);
                end
                total++;
                if (d_idv(d) !== m_idv[d] || d_idpc(d) !== m_idpc[d] || d_idins(d) !== m_idins[d]) begin
                    bad++;
                    $display("FAIL rand_ifid dut%0d n=%0d got v=%b pc=%h inst=%h want %b,%h,%h",
                             d, n, d_idv(d), d_idpc(d), d_idins(d), m_idv[d], m_idpc[d], m_idins[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_branch();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
